float_avg_feeder: RTL
=====================

# float_avg_feeder

Sequential front-end for the floating-point divider in the kNN accelerator's averaging path. It accepts a stream of IEEE-754 single-precision neighbour values over a valid/ready handshake and accumulates their sum with the existing combinational `float_add`. It counts the beats and converts the count to single precision. It then presents the (numerator, denominator) pair to the divider, which produces the mean (sum / k) used for kNN regression output.

## Interface
- `CNT_W`, default 8: beat counter width.
  - Legal range 2..24.
  - Maximum representable count is 2^CNT_W − 1.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_data` in 32: IEEE-754 single value.
- `in_last` in 1: marks the final beat of a group.
- `out_valid` out 1: numerator/denominator pair valid.
- `out_ready` in 1: divider side accepts the pair.
- `out_num` out 32: float sum of the group.
- `out_den` out 32: float representation of the beat count.
- `div_en` out 1: divider enable. Equals `out_valid`.
- `cnt_ovf` out 1: sticky flag; the count saturated in this group.
- `exc` out 1: sticky flag; an input with exponent 8'hFF (Inf/NaN) was seen in this group.

## Operation
- States:
  - IDLE: no group in progress.
  - ACC: accumulating a group.
  - CONV: converting the count to float.
  - HOLD: presenting the result.
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` = 1 in IDLE and ACC, 0 in CONV and HOLD.
- **IDLE, beat accepted:**
  - `sum <= in_data`. The value is loaded directly, not added to +0, so −0 and signs are preserved.
  - `cnt <= 1`.
  - `exc <= (in_data[30:23]==8'hFF)`.
  - `cnt_ovf <= 0`.
  - Next state is ACC, or CONV if `in_last`.
- **ACC, beat accepted:**
  - `sum <= float_add(sum, in_data)`.
  - `cnt <= cnt+1`, saturating at 2^CNT_W − 1. Incrementing at saturation sets `cnt_ovf`; `sum` still updates.
  - `exc |= (in_data[30:23]==8'hFF)`.
  - On `in_last` the next state is CONV.
- **CONV (unsigned integer to float, one shift per cycle):**
  - On entry: `norm = cnt` and `sh = 0`.
  - Each CONV cycle:
    - If `norm[CNT_W-1]==0`: `norm <= norm<<1`, `sh <= sh+1`.
    - Else: latch `out_den = {1'b0, 8'(127+CNT_W-1-sh), norm[CNT_W-2:0], (24-CNT_W) zeros}` and go to HOLD.
  - `cnt` is never 0 here, so the loop always terminates.
  - Conversion is exact; no rounding is needed for CNT_W ≤ 24.
- **HOLD:**
  - `out_valid=1`; `out_num=sum` and `out_den` stay stable.
  - When `out_ready` is sampled high: clear `sum`, `cnt`, `out_den` to 0, then go to IDLE.
  - `cnt_ovf` and `exc` hold their value until the next group's first beat.
- An empty group cannot occur, because `in_last` always rides on a data beat.
- The sum uses `float_add` rounding and exception behaviour unchanged. The block performs no NaN propagation of its own beyond flagging `exc`.

## Timing
- **Reset values:**
  - State IDLE.
  - `in_ready=1`.
  - `out_valid=0`, `div_en=0`.
  - `out_num=0`, `out_den=0`.
  - `cnt_ovf=0`, `exc=0`.
  - Internal `sum`, `cnt`, `norm`, `sh` all 0.
- Reset asserted in any state, including mid-ACC, CONV, or HOLD with `out_valid` high, returns to reset values at the next edge. The partial group is discarded.
- Throughput in ACC is one beat per cycle. `in_valid` gaps are permitted and have no effect.
- **Latency from the edge accepting `in_last` to `out_valid` high:**
  - (CNT_W−1−msb(cnt)) shift cycles, plus 1 detect cycle, so `out_valid` is high at edge +(CNT_W − msb(cnt)).
  - CNT_W=8 examples: count 1 → 8 cycles; count 128..255 → 1 cycle.
- `out_valid` stays high until an edge with `out_ready=1`. `out_valid` falls and `in_ready` rises on that same edge.
- A beat offered in the same cycle as the HOLD handshake is not accepted; it is accepted on the next cycle.
- `out_num` and `out_den` must not change while `out_valid=1`.

## Test plan
- **Three-beat group:** 1.0 (3F800000), 2.0 (40000000), 3.0 (40400000), last on the third beat, `out_ready=1`.
  - Required: `out_num`=40C00000, `out_den`=40400000.
  - `out_valid` at last-beat edge +7 (CNT_W=8); high for 1 cycle.
- **Single-beat group:** 2.5 (40200000) with `in_last`.
  - Required: `out_den`=3F800000, `out_num`=40200000.
  - `in_ready`=0 from edge+1 until the handshake.
- **Backpressure:** hold `out_ready=0` for 10 cycles in HOLD while `in_valid=1`.
  - Required: `out_valid`, `out_num`, `out_den` stable; `in_ready`=0; no beat accepted.
  - After release: next group accepted one cycle later.
- **Counter saturation:** 256 beats of 1.0, CNT_W=8.
  - Required: `cnt_ovf`=1, `out_den`=437F0000 (255.0), `out_num`=43800000 (256.0).
- **Exception flag:** group {1.0, 7FC00000, 2.0}.
  - Required: `exc`=1, held into HOLD. The next clean group clears `exc` on its first beat.
- **Reset mid-CONV:** assert `rst` one cycle during CONV of a 2-beat group, then send {4.0}.
  - Required: all outputs at reset values the cycle after `rst`.
  - Result: `out_num`=40800000, `out_den`=3F800000.

Source files
------------

// File: rtl/float_avg_feeder_if.sv
// ----------------------------------------------------------------------------
// float_avg_feeder_if
//   Bundles the streaming input, the divider-side output pair and the status
//   flags of float_avg_feeder.
//   master : producer/consumer side (drives beats and out_ready)
//   slave  : the feeder itself
// Signals:
//   in_valid/in_ready/in_data/in_last  - IEEE-754 single input beats
//   out_valid/out_ready/out_num/out_den - (sum, count) pair for the divider
//   div_en                              - divider enable (mirrors out_valid)
//   cnt_ovf, exc                        - sticky per-group status flags
// ----------------------------------------------------------------------------
interface float_avg_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_num;
  logic [31:0] out_den;
  logic        div_en;
  logic        cnt_ovf;
  logic        exc;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_num, out_den, div_en, cnt_ovf, exc
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_num, out_den, div_en, cnt_ovf, exc
  );
endinterface

// File: rtl/float_avg_feeder.sv
// ----------------------------------------------------------------------------
// float_avg_feeder
//   Front-end of the kNN averaging divider. Accumulates a group of IEEE-754
//   single values (float_add, round-to-nearest-even), counts the beats,
//   converts the count to single precision one shift per cycle and then
//   holds the (sum, count) pair until the divider takes it.
// Parameters:
//   CNT_W  - beat counter width (2..24); count saturates at 2^CNT_W-1
// Ports:
//   clk    - clock, all state on the rising edge
//   rst    - synchronous active-high reset
//   bus    - float_avg_feeder_if.slave (stream in, pair out, status flags)
// ----------------------------------------------------------------------------
module float_avg_feeder #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  float_avg_feeder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_CONV, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam int               EXP_BASE = 127 + CNT_W - 1;

  state_t           state_reg, state_next;
  logic [31:0]      sum_reg, sum_next;
  logic [31:0]      den_reg, den_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] norm_reg, norm_next;
  logic [4:0]       sh_reg, sh_next;
  logic             ovf_reg, ovf_next;
  logic             exc_reg, exc_next;

  logic             ready;
  logic             accept;
  logic             in_special;
  logic [31:0]      add_result;
  logic [22:0]      den_frac;
  logic [7:0]       den_exp;

  // IEEE-754 single adder, round-to-nearest-even, subnormals supported.
  function automatic logic [31:0] float_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, r;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my;
    logic [26:0] ax, by, by_sh;
    logic [27:0] s;
    logic [9:0]  e;
    logic [24:0] mant;
    logic        sticky, rup;
    r      = '0;
    sticky = 1'b0;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:23] == 8'hFF && a[22:0] != 23'd0)       r = a | 32'h0040_0000;
      else if (b[30:23] == 8'hFF && b[22:0] != 23'd0)  r = b | 32'h0040_0000;
      else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31])
        r = 32'h7FC0_0000;                             // inf - inf
      else if (a[30:23] == 8'hFF)                      r = a;
      else                                             r = b;
    end else begin
      // Larger magnitude goes to x; finite bit patterns order like magnitudes.
      if (a[30:0] >= b[30:0]) begin x = a; y = b; end
      else                    begin x = b; y = a; end
      ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      mx = {x[30:23] != 8'd0, x[22:0]};
      my = {y[30:23] != 8'd0, y[22:0]};
      d  = ex - ey;
      ax = {mx, 3'b000};
      by = {my, 3'b000};
      if (d >= 8'd27) begin
        by_sh = {26'd0, |by};
      end else begin
        by_sh     = by >> d;
        sticky    = ((by_sh << d) != by);
        by_sh[0]  = by_sh[0] | sticky;
      end
      e = {2'b00, ex};
      if (x[31] == y[31]) s = {1'b0, ax} + {1'b0, by_sh};
      else                s = {1'b0, ax} - {1'b0, by_sh};
      if (s == 28'd0) begin
        // Exact cancellation gives +0; only -0 + -0 stays negative.
        r = {x[31] & y[31], 31'd0};
      end else begin
        if (s[27]) begin
          s = {1'b0, s[27:2], s[1] | s[0]};
          e = e + 10'd1;
        end
        for (int i = 0; i < 26; i++) begin
          if (!s[26] && e > 10'd1) begin
            s = s << 1;
            e = e - 10'd1;
          end
        end
        if (!s[26]) e = 10'd0;                  // subnormal result
        rup  = s[2] && (s[1] || s[0] || s[3]);
        mant = {1'b0, s[26:3]} + {24'd0, rup};
        if (mant[24]) begin
          mant = mant >> 1;
          e    = e + 10'd1;
        end else if (e == 10'd0 && mant[23]) begin
          e = 10'd1;                            // subnormal rounded up to normal
        end
        if (e >= 10'd255) r = {x[31], 8'hFF, 23'd0};
        else              r = {x[31], e[7:0], mant[22:0]};
      end
    end
    return r;
  endfunction

  assign ready      = (state_reg == S_IDLE) || (state_reg == S_ACC);
  assign accept     = bus.in_valid && ready;
  assign in_special = (bus.in_data[30:23] == 8'hFF);
  assign add_result = float_add(sum_reg, bus.in_data);

  // Count-to-float packing: the normalised count's leading one is implicit,
  // the remaining CNT_W-1 bits sit at the top of the fraction.
  assign den_exp = 8'(EXP_BASE - int'(sh_reg));
  always_comb begin
    den_frac                 = '0;
    den_frac[22 -: CNT_W-1]  = norm_reg[CNT_W-2:0];
  end

  always_comb begin
    state_next = state_reg;
    sum_next   = sum_reg;
    den_next   = den_reg;
    cnt_next   = cnt_reg;
    norm_next  = norm_reg;
    sh_next    = sh_reg;
    ovf_next   = ovf_reg;
    exc_next   = exc_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (accept) begin
          sum_next = bus.in_data;               // direct load keeps -0 intact
          cnt_next = CNT_ONE;
          exc_next = in_special;
          ovf_next = 1'b0;
          if (bus.in_last) begin
            state_next = S_CONV;
            norm_next  = CNT_ONE;
            sh_next    = 5'd0;
          end else begin
            state_next = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (accept) begin
          sum_next = add_result;
          if (cnt_reg == CNT_MAX) ovf_next = 1'b1;
          else                    cnt_next = cnt_reg + CNT_ONE;
          exc_next = exc_reg | in_special;
          if (bus.in_last) begin
            state_next = S_CONV;
            norm_next  = cnt_next;
            sh_next    = 5'd0;
          end
        end
      end
      S_CONV: begin
        if (!norm_reg[CNT_W-1]) begin
          norm_next = norm_reg << 1;
          sh_next   = sh_reg + 5'd1;
        end else begin
          den_next   = {1'b0, den_exp, den_frac};
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          sum_next   = '0;
          cnt_next   = '0;
          den_next   = '0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      sum_reg   <= '0;
      den_reg   <= '0;
      cnt_reg   <= '0;
      norm_reg  <= '0;
      sh_reg    <= '0;
      ovf_reg   <= 1'b0;
      exc_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sum_reg   <= sum_next;
      den_reg   <= den_next;
      cnt_reg   <= cnt_next;
      norm_reg  <= norm_next;
      sh_reg    <= sh_next;
      ovf_reg   <= ovf_next;
      exc_reg   <= exc_next;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_reg == S_HOLD);
  assign bus.div_en    = (state_reg == S_HOLD);
  assign bus.out_num   = sum_reg;
  assign bus.out_den   = den_reg;
  assign bus.cnt_ovf   = ovf_reg;
  assign bus.exc       = exc_reg;

endmodule
